// File: rtl/local_branch_predictor.sv
// Two-level local branch predictor: per-PC history table (BHT) feeding a table of
// 2-bit saturating counters (PHT). Predicts in F, carries the guess through D/E, trains in E.
module local_branch_predictor #(
  parameter int         BHT_IDX_W = 6,
  parameter int         HIST_W    = 6,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        flushE,
  input  logic        branchD,
  output logic        pred_takeD,
  input  logic        actual_takeE,
  output logic        branch_validE,
  output logic        mispredE
);

  localparam int BHT_N = 2 ** BHT_IDX_W;
  localparam int PHT_N = 2 ** HIST_W;

  logic [HIST_W-1:0]    r_bht [BHT_N];
  logic [1:0]           r_pht [PHT_N];

  // F->D pipeline register
  logic                 r_predD;
  logic [BHT_IDX_W-1:0] r_bidxD;
  logic [HIST_W-1:0]    r_histD;

  // D->E pipeline register
  logic                 r_predE;
  logic                 r_validE;
  logic [BHT_IDX_W-1:0] r_bidxE;
  logic [HIST_W-1:0]    r_histE;

  logic [BHT_IDX_W-1:0] w_bidxF;
  logic [HIST_W-1:0]    w_histF;
  logic                 w_predF;
  logic [1:0]           w_cnt_cur;
  logic [1:0]           w_cnt_nxt;
  logic [HIST_W-1:0]    w_hist_nxt;
  logic                 w_unused_pc;

  // Fetch lookup reads registered tables only, so a same-cycle E update is not visible here.
  assign w_bidxF     = pcF[BHT_IDX_W+1:2];
  assign w_histF     = r_bht[w_bidxF];
  assign w_predF     = r_pht[w_histF][1];
  assign w_unused_pc = ^{pcF[31:BHT_IDX_W+2], pcF[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_predD <= 1'b0;
      r_bidxD <= '0;
      r_histD <= '0;
    end else if (flushD) begin
      r_predD <= 1'b0;
      r_bidxD <= '0;
      r_histD <= '0;
    end else if (!stallD) begin
      r_predD <= w_predF;
      r_bidxD <= w_bidxF;
      r_histD <= w_histF;
    end
  end

  // A stalled D must not also advance into E, so a stall inserts a bubble just like flushE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_predE  <= 1'b0;
      r_validE <= 1'b0;
      r_bidxE  <= '0;
      r_histE  <= '0;
    end else if (flushE || stallD) begin
      r_predE  <= 1'b0;
      r_validE <= 1'b0;
      r_bidxE  <= '0;
      r_histE  <= '0;
    end else begin
      r_predE  <= r_predD & branchD;
      r_validE <= branchD;
      r_bidxE  <= r_bidxD;
      r_histE  <= r_histD;
    end
  end

  always_comb begin
    w_cnt_cur = r_pht[r_histE];
    w_cnt_nxt = w_cnt_cur;
    if (actual_takeE) begin
      w_cnt_nxt = (w_cnt_cur == 2'b11) ? 2'b11 : w_cnt_cur + 2'b01;
    end else begin
      w_cnt_nxt = (w_cnt_cur == 2'b00) ? 2'b00 : w_cnt_cur - 2'b01;
    end
  end

  assign w_hist_nxt = {r_bht[r_bidxE][HIST_W-2:0], actual_takeE};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= '0;
      for (int j = 0; j < PHT_N; j++) r_pht[j] <= CNT_INIT;
    end else if (r_validE) begin
      r_pht[r_histE] <= w_cnt_nxt;
      r_bht[r_bidxE] <= w_hist_nxt;
    end
  end

  // branch_validE qualifies actual_takeE and mispredE; both are don't-care while it is low.
  assign pred_takeD    = r_predD;
  assign branch_validE = r_validE;
  assign mispredE      = r_validE & (r_predE ^ actual_takeE);

endmodule

// File: doc/local_branch_predictor.md
Name: local_branch_predictor

Overview:
- Two-level local branch predictor for the 5-stage MIPS pipeline. It sits beside fetch and produces the taken/not-taken guess that steers the next PC.
- Level 1: a per-PC local branch history table (BHT). Level 2: a pattern history table (PHT) of 2-bit saturating counters, indexed by that history.
- Tracks each prediction through D and E. Flags a mispredict when the branch resolves in E, and trains both tables at the same point.

Parameters:
- BHT_IDX_W, 6, BHT index width; index = pcF[BHT_IDX_W+1:2]; 2^BHT_IDX_W entries.
- HIST_W, 6, local history length; the PHT has 2^HIST_W entries indexed by history.
- CNT_INIT, 2'b01, reset value of every PHT counter (weakly not-taken).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- pcF  in  32  fetch-stage PC
- stallD  in  1  hold the F->D pipeline register
- flushD  in  1  clear the F->D register (bubble)
- flushE  in  1  clear the D->E register (bubble)
- branchD  in  1  decode: instruction in D is a conditional branch
- pred_takeD  out  1  prediction for the instruction in D
- actual_takeE  in  1  resolved branch outcome in E; valid when branch_validE=1
- branch_validE  out  1  E holds a predicted conditional branch
- mispredE  out  1  branch_validE & (pred_takeE != actual_takeE)

Behaviour:
- Reset (rst=0, async):
  - All BHT entries = 0; all PHT counters = CNT_INIT.
  - Pipeline regs cleared: pred_takeD=0, branch_validE=0, mispredE=0.
- Lookup in F (combinational read of registered state):
  - bidxF = pcF[BHT_IDX_W+1:2]; histF = BHT[bidxF]; predF = PHT[histF][1].
- F->D register, priority flushD > stallD > load:
  - Load captures {predF, bidxF, histF}.
  - Flush clears the register, so pred_takeD=0.
  - Stall holds the register.
- D->E register:
  - Loads {pred_takeD & branchD, branchD, bidx, hist} every cycle.
  - Loads a bubble (branch_validE=0) when flushE=1 or stallD=1.
- Update on a clock edge where branch_validE=1:
  - PHT[histE]: +1 if actual_takeE, saturating at 3; -1 otherwise, saturating at 0.
  - BHT[bidxE] = {BHT[bidxE][HIST_W-2:0], actual_takeE} (shift in at LSB).
  - Non-branch or bubble in E: no table writes.
- Latency:
  - Prediction for pcF appears on pred_takeD one cycle after pcF is presented, if the F->D register is not stalled.
  - mispredE is valid in the same cycle the branch is in E.
- Boundary conditions:
  - Read-during-write (E updates the entry F is reading in the same cycle): F sees the OLD value. No bypass.
  - Aliasing: PCs with equal pc[7:2] share a BHT entry, and equal histories share a PHT counter. This is allowed and not detected.
  - Counter saturation: 3 + taken stays 3; 0 + not-taken stays 0. Never wraps.
  - stallD and flushE both asserted: D holds, E gets a bubble, no update from the bubble.
  - Reset mid-operation (async assert): clears all state immediately. The first prediction after release uses CNT_INIT, giving predF=0.
- Only conditional branches are predicted and trained. Jumps are not.

Test Plan:
1. Reset then present pcF=0x10 with branchD=1 and actual_takeE=1 -> pred_takeD=0, mispredE=1 in E. After the edge: BHT[4]=6'b000001, PHT[0]=2'b10.
2. Same branch (pcF=0x10) resolved taken 8 consecutive times -> BHT[4] saturates to 6'b111111. PHT[63] trains until pred_takeD=1. Once trained, mispredE=0.
3. Loop pattern T,T,T,N repeated 20 times at pcF=0x20 -> after warm-up (≤12 executions) mispredE=0 for every later occurrence, both taken and not-taken.
4. Update and lookup of BHT[4] in the same cycle -> pred_takeD reflects the pre-update history. The next fetch of 0x10 reflects the new history.
5. flushE=1 while a branch is in D -> branch_validE=0 the next cycle, mispredE=0, no PHT/BHT change. Same check for stallD=1.
6. Drive rst=0 asynchronously mid-stream with branch_validE=1 -> outputs go to 0 without waiting for a clk edge, and all counters read back as 2'b01.
